// File: rtl/wb_pic_8259_if.sv
// Wishbone I/O slave bus bundle for the 8259-style interrupt controller.
//   wb_dat_i  16  write data, [7:0] = port 0x20, [15:8] = port 0x21
//   wb_dat_o  16  read data {IMR, IRR-or-ISR}
//   wb_sel_i   2  byte lanes, sel[0] = 0x20, sel[1] = 0x21
//   wb_we_i    1  write enable
//   wb_stb_i   1  strobe, already qualified by the I/O address decode
//   wb_cyc_i   1  bus cycle
//   wb_ack_o   1  single-cycle acknowledge
// master = cpu/bus side, slave = controller side.
interface wb_pic_8259_if;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic [1:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;

   modport master (
      output wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_pic_8259.sv
// Interrupt controller at I/O ports 0x20/0x21, a subset of the 8259A.
// Latches rising edges of int_i into IRR, masks them with IMR, and raises
// intr_o for the highest-priority pending line (bit 0 highest) that outranks
// everything currently in service. The cpu acknowledge (inta_i rising edge)
// moves the request from IRR into ISR; software retires it with an EOI.
// Ports:
//   wb_clk_i, wb_rst_i  clock, synchronous active-high reset
//   wb                  Wishbone slave bundle (data, sel, we, stb, cyc, ack)
//   int_i[7:0]          interrupt request lines
//   inta_i              cpu interrupt acknowledge
//   intr_o              interrupt request to the cpu
//   iid_o[2:0]          index of the interrupt being acknowledged (7 = spurious)
//   vec_o[7:0]          {VECTOR_BASE, iid_o}
module wb_pic_8259 #(
   parameter logic [4:0] VECTOR_BASE = 5'b00001,
   parameter logic [7:0] RESET_IMR   = 8'h00
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   wb_pic_8259_if.slave wb,
   input  logic [7:0]   int_i,
   input  logic         inta_i,
   output logic         intr_o,
   output logic [2:0]   iid_o,
   output logic [7:0]   vec_o
);

   logic [7:0] irr, isr, imr;
   logic [7:0] int_q;
   logic       inta_q;
   logic       commit_q;
   logic       rd_sel;
   logic       ack;

   logic [7:0] pend;
   logic [2:0] top_p;
   logic [3:0] top_s;
   logic       eligible;
   logic       commit;
   logic       commit_ok;
   logic       wr, wr_lo, wr_hi;
   logic [7:0] d;
   logic [7:0] isr_clr, isr_set, irr_clr, edges;
   logic       ocw3;

   assign pend = irr & ~imr;

   // lowest set index wins; loop runs high-to-low so the last hit is the lowest
   always_comb begin
      top_p = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (pend[i]) top_p = 3'(i);
   end

   // 8 means nothing in service, so any pending line outranks it
   always_comb begin
      top_s = 4'd8;
      for (int i = 7; i >= 0; i--)
         if (isr[i]) top_s = 4'(i);
   end

   assign eligible  = (|pend) && ({1'b0, top_p} < top_s);
   assign commit    = inta_i & ~inta_q;
   assign commit_ok = commit & eligible;
   assign edges     = int_i & ~int_q;

   // write side effects land on the edge that ends the ack cycle, once per access
   assign wr    = ack & wb.wb_stb_i & wb.wb_cyc_i & wb.wb_we_i;
   assign wr_lo = wr & wb.wb_sel_i[0];
   assign wr_hi = wr & wb.wb_sel_i[1];
   assign d     = wb.wb_dat_i[7:0];
   assign ocw3  = wr_lo && (d[4:3] == 2'b01) && d[1];

   always_comb begin
      isr_clr = 8'h00;
      if (wr_lo) begin
         if (d[7:5] == 3'b001) begin
            if (top_s != 4'd8) isr_clr[top_s[2:0]] = 1'b1;
         end else if (d[7:5] == 3'b011) begin
            isr_clr[d[2:0]] = 1'b1;
         end
      end
   end

   // iid_o is frozen while inta_i is high, so it names the line being committed
   assign isr_set = commit_ok ? (8'h01 << iid_o) : 8'h00;
   assign irr_clr = isr_set;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         irr      <= 8'h00;
         isr      <= 8'h00;
         imr      <= RESET_IMR;
         int_q    <= 8'h00;
         inta_q   <= 1'b0;
         commit_q <= 1'b0;
         rd_sel   <= 1'b0;
         ack      <= 1'b0;
         intr_o   <= 1'b0;
         iid_o    <= 3'd0;
      end else begin
         int_q    <= int_i;
         inta_q   <= inta_i;
         commit_q <= commit;
         ack      <= wb.wb_stb_i & wb.wb_cyc_i & ~ack;
         // clear-then-set: a new edge or a commit beats a same-cycle clear
         irr      <= (irr & ~irr_clr) | edges;
         isr      <= (isr & ~isr_clr) | isr_set;
         if (wr_hi) imr <= wb.wb_dat_i[15:8];
         if (ocw3) rd_sel <= d[0];
         // hold intr_o low across the commit so the cpu can't see a stale request
         intr_o   <= eligible & ~commit & ~commit_q;
         if (commit && !eligible) iid_o <= 3'd7;
         else if (!inta_i)        iid_o <= top_p;
      end
   end

   assign wb.wb_ack_o = ack;
   assign wb.wb_dat_o = {imr, rd_sel ? isr : irr};
   assign vec_o       = {VECTOR_BASE, iid_o};

endmodule

// File: tb/tb_wb_pic_8259.sv
module tb_wb_pic_8259;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] int_i;
   logic       inta;
   logic       intr;
   logic [2:0] iid;
   logic [7:0] vec;
   int         total  = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   wb_pic_8259_if bus();

   wb_pic_8259 #(.VECTOR_BASE(5'b00001), .RESET_IMR(8'h00)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .int_i    (int_i),
      .inta_i   (inta),
      .intr_o   (intr),
      .iid_o    (iid),
      .vec_o    (vec)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one Wishbone access; stb held through the ack cycle so writes take effect
   task automatic xfer(input logic we, input logic [1:0] sel, input logic [15:0] dat,
                       output logic [15:0] rdat);
      int n;
      @(negedge clk);
      bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
      bus.wb_we_i  = we;   bus.wb_sel_i = sel; bus.wb_dat_i = dat;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.wb_ack_o && n < 4);
      chk("ack_latency", 16'(n), 16'd1);
      rdat = bus.wb_dat_o;
      @(posedge clk); #1;
      chk("ack_pulse", {15'b0, bus.wb_ack_o}, 16'h0000);
      @(negedge clk);
      bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [15:0] dat);
      logic [15:0] r;
      xfer(1'b1, sel, dat, r);
   endtask

   task automatic rd(input string tag, input logic [1:0] sel, input logic [15:0] exp);
      logic [15:0] r;
      xfer(1'b0, sel, 16'h0000, r);
      chk(tag, r, exp);
   endtask

   // one-cycle pulse on int_i[n]; intr_o checked at both latency edges
   task automatic pulse_int(input int n, input logic exp2);
      @(negedge clk); int_i[n] = 1'b1;
      tick(1);
      chk("intr_lat1", {15'b0, intr}, 16'h0000);
      tick(1);
      chk("intr_lat2", {15'b0, intr}, {15'b0, exp2});
      @(negedge clk); int_i[n] = 1'b0;
   endtask

   task automatic do_inta(input logic [7:0] exp_vec);
      @(negedge clk); inta = 1'b1;
      tick(1);
      chk("vec", {8'h00, vec}, {8'h00, exp_vec});
      chk("intr_commit", {15'b0, intr}, 16'h0000);
      @(negedge clk); inta = 1'b0;
   endtask

   initial begin
      rst = 1'b1; int_i = 8'h00; inta = 1'b0;
      bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_sel_i = 2'b00; bus.wb_dat_i = 16'h0000;

      // 1: reset state and plain reads
      tick(3);
      chk("rst_intr", {15'b0, intr}, 16'h0000);
      chk("rst_iid",  {13'b0, iid},  16'h0000);
      chk("rst_ack",  {15'b0, bus.wb_ack_o}, 16'h0000);
      chk("rst_dat",  bus.wb_dat_o, 16'h0000);
      @(negedge clk); rst = 1'b0;
      rd("rd_20", 2'b01, 16'h0000);
      rd("rd_21", 2'b10, 16'h0000);
      chk("idle_intr", {15'b0, intr}, 16'h0000);

      // 2: single request, acknowledge, ISR readback
      pulse_int(0, 1'b1);
      chk("t2_iid", {13'b0, iid}, 16'h0000);
      do_inta(8'h08);
      wr(2'b01, 16'h000B);
      rd("t2_isr", 2'b01, 16'h0001);
      chk("t2_intr", {15'b0, intr}, 16'h0000);
      wr(2'b01, 16'h000A);
      rd("t2_irr", 2'b01, 16'h0000);

      // 3: nesting, higher priority preempts line 4 in service
      wr(2'b01, 16'h0020);
      pulse_int(4, 1'b1);
      chk("t3_iid4", {13'b0, iid}, 16'h0004);
      do_inta(8'h0C);
      wr(2'b01, 16'h000B);
      rd("t3_isr10", 2'b01, 16'h0010);
      pulse_int(0, 1'b1);
      chk("t3_iid0", {13'b0, iid}, 16'h0000);
      do_inta(8'h08);
      rd("t3_isr11", 2'b01, 16'h0011);
      wr(2'b01, 16'h0020);
      rd("t3_eoi1", 2'b01, 16'h0010);
      wr(2'b01, 16'h0020);
      rd("t3_eoi2", 2'b01, 16'h0000);

      // 4: masked request stays in IRR, unmask releases it
      wr(2'b01, 16'h000A);
      wr(2'b10, 16'h0100);
      pulse_int(0, 1'b0);
      rd("t4_irr", 2'b01, 16'h0101);
      wr(2'b10, 16'h0000);
      chk("t4_unmask0", {15'b0, intr}, 16'h0000);
      tick(1);
      chk("t4_unmask1", {15'b0, intr}, 16'h0001);
      do_inta(8'h08);
      wr(2'b01, 16'h0020);

      // 5: level held high latches one request only
      @(negedge clk); int_i[1] = 1'b1;
      tick(50);
      chk("t5_intr", {15'b0, intr}, 16'h0001);
      chk("t5_iid",  {13'b0, iid},  16'h0001);
      do_inta(8'h09);
      wr(2'b01, 16'h0020);
      tick(10);
      chk("t5_quiet", {15'b0, intr}, 16'h0000);
      rd("t5_irr", 2'b01, 16'h0000);
      @(negedge clk); int_i[1] = 1'b0;

      // 6: reset during inta with ISR busy and IMR changed
      wr(2'b10, 16'h8000);
      pulse_int(2, 1'b1);
      @(negedge clk); inta = 1'b1;
      tick(1);
      chk("t6_vec", {8'h00, vec}, 16'h000A);
      wr(2'b01, 16'h000B);
      rd("t6_isr", 2'b01, 16'h8004);
      @(negedge clk); rst = 1'b1;
      tick(1);
      chk("t6_intr", {15'b0, intr}, 16'h0000);
      chk("t6_iid",  {13'b0, iid},  16'h0000);
      chk("t6_dat",  bus.wb_dat_o,  16'h0000);
      @(negedge clk); rst = 1'b0; inta = 1'b0;
      wr(2'b01, 16'h000B);
      rd("t6_isr0", 2'b01, 16'h0000);

      // spurious acknowledge with nothing pending reports line 7
      do_inta(8'h0F);
      chk("spur_iid", {13'b0, iid}, 16'h0007);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
